// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for the toggle-EN packet buffer RAM.
// Also runs a zero-fill clear sweep over the whole RAM on request.
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              A_REQ,
    input  logic              A_WR,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DIN,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_DOUT,
    input  logic              B_REQ,
    input  logic              B_WR,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DIN,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_DOUT,
    output logic              M_EN,
    output logic              M_WR,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_DIN,
    input  logic [DATA_W-1:0] M_DOUT
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RELEASE,
        S_CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic                en_q, en_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DATA_W-1:0]   dout_a_q, dout_a_d;
    logic [DATA_W-1:0]   dout_b_q, dout_b_d;
    logic                busy_q, busy_d;
    logic                prio_b_q, prio_b_d;
    logic                sel_b_q, sel_b_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                ph_q, ph_d;
    logic                grant_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            dout_a_q <= '0;
            dout_b_q <= '0;
            busy_q   <= 1'b0;
            prio_b_q <= 1'b0;
            sel_b_q  <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            busy_q   <= busy_d;
            prio_b_q <= prio_b_d;
            sel_b_q  <= sel_b_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        din_d    = din_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        busy_d   = busy_q | CLR;
        prio_b_d = prio_b_q;
        sel_b_d  = sel_b_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        grant_b  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CLR || busy_q) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    ph_d    = 1'b0;
                end else if (A_REQ || B_REQ) begin
                    grant_b  = B_REQ && (!A_REQ || prio_b_q);
                    sel_b_d  = grant_b;
                    prio_b_d = !grant_b;
                    wr_d     = grant_b ? B_WR : A_WR;
                    addr_d   = grant_b ? B_ADDR : A_ADDR;
                    din_d    = grant_b ? B_DIN : A_DIN;
                    en_d     = ~en_q;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!wr_q) begin
                    if (sel_b_q) dout_b_d = M_DOUT;
                    else dout_a_d = M_DOUT;
                end
                ack_a_d = !sel_b_q;
                ack_b_d = sel_b_q;
                wr_d    = 1'b0;
                state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            S_CLEAR: begin
                busy_d = 1'b1;
                if (!ph_q) begin
                    en_d   = ~en_q;
                    wr_d   = 1'b1;
                    din_d  = '0;
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    ph_d   = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    // Top counter bit set: every address has been written.
                    if (cnt_q[ADDR_W]) begin
                        wr_d    = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY   = busy_q;
    assign A_ACK  = ack_a_q;
    assign A_DOUT = dout_a_q;
    assign B_ACK  = ack_b_q;
    assign B_DOUT = dout_b_q;
    assign M_EN   = en_q;
    assign M_WR   = wr_q;
    assign M_ADDR = addr_q;
    assign M_DIN  = din_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: toggle-EN RAM model, vector table, random rounds
// against a transaction-level model, and clear/reset corner sequences.
module tb_mem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CLR = 1'b0;
    logic          BUSY;
    logic          A_REQ = 1'b0, A_WR = 1'b0;
    logic [AW-1:0] A_ADDR = '0;
    logic [DW-1:0] A_DIN = '0;
    logic          A_ACK;
    logic [DW-1:0] A_DOUT;
    logic          B_REQ = 1'b0, B_WR = 1'b0;
    logic [AW-1:0] B_ADDR = '0;
    logic [DW-1:0] B_DIN = '0;
    logic          B_ACK;
    logic [DW-1:0] B_DOUT;
    logic          M_EN, M_WR;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_DIN;
    logic [DW-1:0] M_DOUT;

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY),
        .A_REQ(A_REQ), .A_WR(A_WR), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
        .A_ACK(A_ACK), .A_DOUT(A_DOUT),
        .B_REQ(B_REQ), .B_WR(B_WR), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
        .B_ACK(B_ACK), .B_DOUT(B_DOUT),
        .M_EN(M_EN), .M_WR(M_WR), .M_ADDR(M_ADDR), .M_DIN(M_DIN),
        .M_DOUT(M_DOUT)
    );

    // Toggle-EN RAM: one access whenever EN differs from the last sampled EN.
    logic [DW-1:0] ram [0:511];
    logic          ram_en;
    bit            ram_init;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ram_en <= 1'b0;
            if (!ram_init) begin
                for (int i = 0; i < 512; i++) ram[i] <= '0;
                ram_init <= 1'b1;
            end
        end else if (M_EN != ram_en) begin
            ram_en <= M_EN;
            if (M_WR) ram[M_ADDR] <= M_DIN;
            M_DOUT <= ram[M_ADDR];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int tog = 0;
    logic en_prev = 1'b0;
    bit tog_prev = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            en_prev  = M_EN;
            tog_prev = 1'b0;
        end else if (M_EN !== en_prev) begin
            tog++;
            chk("en_spacing", 32'(tog_prev), 32'd0);
            tog_prev = 1'b1;
            en_prev  = M_EN;
        end else begin
            tog_prev = 1'b0;
        end
    end

    logic [DW-1:0] ref_mem [0:511];
    bit            ref_prio_b;
    logic [DW-1:0] ref_qa, ref_qb;

    task automatic check_rst(input string tag);
        chk({tag, " BUSY"}, 32'(BUSY), 0);
        chk({tag, " M_EN"}, 32'(M_EN), 0);
        chk({tag, " M_WR"}, 32'(M_WR), 0);
        chk({tag, " M_ADDR"}, 32'(M_ADDR), 0);
        chk({tag, " M_DIN"}, M_DIN, 0);
        chk({tag, " A_ACK"}, 32'(A_ACK), 0);
        chk({tag, " B_ACK"}, 32'(B_ACK), 0);
        chk({tag, " A_DOUT"}, A_DOUT, 0);
        chk({tag, " B_DOUT"}, B_DOUT, 0);
    endtask

    task automatic release_rst;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        CLR   = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        ref_prio_b = 1'b0;
        ref_qa = '0;
        ref_qb = '0;
    endtask

    // One round from IDLE: each raised port gets exactly one access.
    task automatic run_round(input bit ra, rb, wa, wb,
                             input logic [AW-1:0] aa, ab,
                             input logic [DW-1:0] da, db,
                             input bit bf, input logic [DW-1:0] eqa, eqb,
                             input string tag);
        int ea, eb, last, t0;
        ea = ra ? ((rb && bf) ? 7 : 3) : 0;
        eb = rb ? ((ra && !bf) ? 7 : 3) : 0;
        last = (ea > eb) ? ea : eb;
        t0 = tog;
        A_REQ = ra; A_WR = wa; A_ADDR = aa; A_DIN = da;
        B_REQ = rb; B_WR = wb; B_ADDR = ab; B_DIN = db;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge CLK);
            chk($sformatf("%s A_ACK c%0d", tag, c), 32'(A_ACK), 32'(c == ea));
            chk($sformatf("%s B_ACK c%0d", tag, c), 32'(B_ACK), 32'(c == eb));
            if (c == ea) begin
                chk({tag, " A_DOUT"}, A_DOUT, eqa);
                A_REQ = 1'b0;
            end
            if (c == eb) begin
                chk({tag, " B_DOUT"}, B_DOUT, eqb);
                B_REQ = 1'b0;
            end
        end
        chk({tag, " A_DOUT end"}, A_DOUT, eqa);
        chk({tag, " B_DOUT end"}, B_DOUT, eqb);
        chk({tag, " toggles"}, tog - t0, int'(ra) + int'(rb));
        if (rb && bf && wb) ref_mem[ab] = db;
        if (ra && wa) ref_mem[aa] = da;
        if (rb && !bf && wb) ref_mem[ab] = db;
        ref_prio_b = (ra && rb) ? bf : ra;
        ref_qa = eqa;
        ref_qb = eqb;
    endtask

    task automatic auto_round(input bit ra, rb, wa, wb,
                              input logic [AW-1:0] aa, ab,
                              input logic [DW-1:0] da, db,
                              input string tag);
        bit bf;
        logic [DW-1:0] eqa, eqb;
        bf = (ra && rb) ? ref_prio_b : rb;
        eqa = ref_qa;
        eqb = ref_qb;
        if (ra && !wa) eqa = (rb && wb && bf && ab == aa) ? db : ref_mem[aa];
        if (rb && !wb) eqb = (ra && wa && !bf && aa == ab) ? da : ref_mem[ab];
        run_round(ra, rb, wa, wb, aa, ab, da, db, bf, eqa, eqb, tag);
    endtask

    typedef struct {
        bit ra, rb, wa, wb;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;
        bit bf;
        logic [DW-1:0] eqa, eqb;
    } vec_t;

    vec_t tv [7];

    initial begin
        int n, early, t0;
        bit ra, rb;
        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'h005, 9'h000, 32'hDEADBEEF, 32'h0,
                  1'b0, 32'h0, 32'h0};
        tv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h005, 9'h000, 32'h0, 32'h0,
                  1'b0, 32'hDEADBEEF, 32'h0};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h1FF, 32'h0, 32'h12345678,
                  1'b1, 32'hDEADBEEF, 32'h0};
        tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h1FF, 9'h000, 32'h0, 32'h0,
                  1'b0, 32'h12345678, 32'h0};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'h064, 9'h1FF, 32'hAAAA5555, 32'h0,
                  1'b1, 32'h12345678, 32'h12345678};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 9'h064, 9'h000, 32'h0, 32'h0F0F0F0F,
                  1'b1, 32'hAAAA5555, 32'h12345678};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'h000, 9'h064, 32'h0, 32'h0,
                  1'b1, 32'h0F0F0F0F, 32'hAAAA5555};
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;

        #1 RST = 1'b1;
        #1 check_rst("reset");
        release_rst();

        for (int i = 0; i < 7; i++)
            run_round(tv[i].ra, tv[i].rb, tv[i].wa, tv[i].wb, tv[i].aa,
                      tv[i].ab, tv[i].da, tv[i].db, tv[i].bf, tv[i].eqa,
                      tv[i].eqb, $sformatf("vec%0d", i));

        // Both ports held for four back-to-back accesses after reset.
        RST = 1'b1;
        release_rst();
        t0 = tog;
        A_REQ = 1'b1; A_WR = 1'b1; A_ADDR = 9'h0AA; A_DIN = 32'h0000_00AA;
        B_REQ = 1'b1; B_WR = 1'b0; B_ADDR = 9'h1FF;
        for (int c = 1; c <= 16; c++) begin
            @(negedge CLK);
            chk($sformatf("rr A_ACK c%0d", c), 32'(A_ACK), 32'(c == 3 || c == 11));
            chk($sformatf("rr B_ACK c%0d", c), 32'(B_ACK), 32'(c == 7 || c == 15));
            if (c == 7 || c == 15) chk("rr B_DOUT", B_DOUT, 32'h12345678);
            if (c == 11) A_REQ = 1'b0;
            if (c == 15) B_REQ = 1'b0;
        end
        chk("rr toggles", tog - t0, 4);
        ref_mem[9'h0AA] = 32'h0000_00AA;
        ref_qb = 32'h12345678;
        ref_prio_b = 1'b0;

        for (int r = 0; r < 40; r++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            auto_round(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       9'($urandom_range(0, 7)), 9'($urandom_range(0, 7)),
                       $urandom, $urandom, $sformatf("rnd%0d", r));
        end

        // Full clear sweep.
        auto_round(1, 1, 1, 1, 9'd0, 9'd100, 32'h1111_0000, 32'h2222_0100, "fill0");
        auto_round(1, 0, 1, 0, 9'd511, 9'd0, 32'h3333_01FF, 32'h0, "fill1");
        t0 = tog;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        n = 0;
        while (BUSY && n < 1100) begin
            n++;
            @(negedge CLK);
        end
        chk("sweep busy cycles", n, 1024);
        chk("sweep toggles", tog - t0, 512);
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        run_round(1, 0, 0, 0, 9'd0, 9'd0, 0, 0, 0, 32'h0, ref_qb, "clr0");
        run_round(0, 1, 0, 0, 9'd0, 9'd100, 0, 0, 1, 32'h0, 32'h0, "clr100");
        run_round(1, 0, 0, 0, 9'd511, 9'd0, 0, 0, 0, 32'h0, 32'h0, "clr511");

        // CLR while a read is in ISSUE; B request raised mid-sweep.
        auto_round(1, 0, 1, 0, 9'h064, 9'h0, 32'h55AA55AA, 32'h0, "pre");
        A_REQ = 1'b1; A_WR = 1'b0; A_ADDR = 9'h064;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("busy after CLR", 32'(BUSY), 1);
        @(negedge CLK);
        chk("inflight A_ACK", 32'(A_ACK), 1);
        chk("inflight A_DOUT", A_DOUT, 32'h55AA55AA);
        A_REQ = 1'b0;
        repeat (100) @(negedge CLK);
        chk("busy mid sweep", 32'(BUSY), 1);
        B_REQ = 1'b1; B_WR = 1'b1; B_ADDR = 9'h033; B_DIN = 32'hCAFEF00D;
        n = 0;
        early = 0;
        while (BUSY && n < 1200) begin
            @(negedge CLK);
            n++;
            if (B_ACK) early++;
        end
        chk("sweep end", 32'(BUSY), 0);
        chk("B acks during sweep", early, 0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge CLK);
            chk($sformatf("post-clear B_ACK k%0d", k), 32'(B_ACK), 32'(k == 3));
            if (k == 3) B_REQ = 1'b0;
        end
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        ref_mem[9'h033] = 32'hCAFEF00D;
        ref_qa = 32'h55AA55AA;
        ref_prio_b = 1'b0;
        auto_round(1, 1, 0, 0, 9'h033, 9'h064, 0, 0, "after clr");

        // Asynchronous reset mid-CLEAR.
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        repeat (50) @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_rst("rst clear");
        release_rst();

        // Asynchronous reset mid-ISSUE.
        A_REQ = 1'b1; A_WR = 1'b1; A_ADDR = 9'h150; A_DIN = 32'h0BAD_0BAD;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_rst("rst issue");
        release_rst();
        auto_round(1, 0, 1, 0, 9'h150, 9'h0, 32'hA5A5_0001, 32'h0, "post rst wr");
        auto_round(1, 0, 0, 0, 9'h150, 9'h0, 32'h0, 32'h0, "post rst rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared 512x32 packet buffer RAM. That RAM performs one access on every clock edge at which its EN input differs from the EN value it sampled at its previous access.
- Arbitrates between two requesters, round-robin: port A is the RX write-side engine, port B is the host/TX access side.
- Drives the RAM's toggle-EN protocol, captures read data, and returns a one-cycle ACK to the requester.
- Provides a clear sweep that zero-fills the whole RAM on request.

Parameters:
- ADDR_W, 9, RAM address width; depth is 2**ADDR_W words.
- DATA_W, 32, RAM data width.

Ports:
- CLK  in  1  single clock for the block and the RAM.
- RST  in  1  reset, asynchronous, active-high.
- CLR  in  1  one-cycle pulse; starts a zero-fill sweep of the whole RAM.
- BUSY  out  1  high while a clear sweep is pending or running.
- A_REQ  in  1  port A request; held high until A_ACK.
- A_WR  in  1  port A: 1 = write, 0 = read.
- A_ADDR  in  ADDR_W  port A word address.
- A_DIN  in  DATA_W  port A write data.
- A_ACK  out  1  one-cycle pulse; port A access complete.
- A_DOUT  out  DATA_W  port A read data; valid while A_ACK is high.
- B_REQ, B_WR, B_ADDR, B_DIN, B_ACK, B_DOUT: same as port A, for port B.
- M_EN  out  1  RAM access toggle.
- M_WR  out  1  RAM write enable.
- M_ADDR  out  ADDR_W  RAM address.
- M_DIN  out  DATA_W  RAM write data.
- M_DOUT  in  DATA_W  RAM registered read data.

Behaviour:
- All outputs are registered.
- Reset values: M_EN=0, M_WR=0, M_ADDR=0, M_DIN=0, A_ACK=B_ACK=0, A_DOUT=B_DOUT=0, BUSY=0. Round-robin pointer is set so that A wins first. State is IDLE.
- Every RAM access is issued by inverting M_EN. M_EN is never toggled on two consecutive edges.
- Requester contract:
  - Hold REQ high with WR/ADDR/DIN stable until ACK is seen.
  - May drop REQ, or present a new request, on the edge where ACK is high.
  - REQ is ignored while ACK is high for that port.
- State machine: IDLE, ISSUE, CAPTURE, RELEASE, CLEAR.
- IDLE (CLR latched, or BUSY pending):
  - Goes to CLEAR with sweep address 0.
  - The clear takes priority over both ports.
- IDLE (any REQ high):
  - Picks the winner. If only one port requests, it wins. If both request, the port not granted last wins.
  - Loads M_WR/M_ADDR/M_DIN from the winner, toggles M_EN, updates the pointer, goes to ISSUE.
- ISSUE: the RAM performs the access at this edge; next state is CAPTURE.
- CAPTURE:
  - On a read, latches M_DOUT into the winner's DOUT. On a write, DOUT holds its previous value.
  - Pulses the winner's ACK for exactly one cycle.
  - Forces M_WR=0 and goes to RELEASE.
- RELEASE: one-cycle guard so the requester can drop REQ; next state is IDLE.
- Latency: a REQ sampled in IDLE gives ACK high 3 cycles later. Per-port throughput is one access per 4 cycles.
- CLEAR:
  - Issues writes of 0 to addresses 0..2**ADDR_W-1, one every 2 cycles (M_EN toggles every other edge, M_WR=1, M_DIN=0).
  - After the final write at the last address, M_WR=0, BUSY drops and the state returns to IDLE.
  - A full sweep takes 1024 cycles at the defaults.
  - The sweep address counter is ADDR_W+1 bits wide, so the terminal condition does not rely on wrap-around.
- CLR handling:
  - A CLR pulse sets BUSY on the next edge in any state.
  - An access already in flight completes normally (ACK delivered) before CLEAR starts.
  - CLR during CLEAR is ignored; it does not restart the sweep.
- REQ asserted during CLEAR waits, is not lost, and is served in round-robin order afterwards.
- Asynchronous RST in any state returns everything to reset values immediately.
  - The RAM's own EN tracking register is outside this block; after reset, the RAM's EN tracking is taken to equal 0.
- Addresses are used as given; no range checks are needed because the width matches the depth.

Test Plan:
- Reset, then A write addr 0x005 data 0xDEADBEEF, then A read 0x005 -> second A_ACK arrives 3 cycles after REQ with A_DOUT=0xDEADBEEF; M_EN toggles exactly once per access.
- A and B REQ together in the same cycle, both held for 4 accesses (B reads 0x1FF) -> grants alternate A,B,A,B; each ACK is a single cycle on the correct port only.
- B write 0x1FF data 0x12345678, then A read 0x1FF -> A_DOUT=0x12345678; B_DOUT unchanged.
- Fill addrs 0,100,511 with non-zero data, pulse CLR -> BUSY high for ~1024 cycles; afterwards reads of 0,100,511 return 0x00000000.
- CLR pulsed while an A read is in ISSUE -> A_ACK is still delivered with correct data, then the sweep runs. B_REQ raised mid-sweep -> served right after BUSY falls.
- Assert RST mid-CLEAR and mid-ISSUE -> all outputs return to reset values on the same cycle and BUSY=0. The next request after RST release completes with 3-cycle latency.
